// File: rtl/amplitude_ramp_ctrl.sv
// Multi-channel AXI-Stream gain stage: two-stage multiply / round / saturate pipeline
// with a shared gain that ramps linearly toward a programmed target on accepted beats.
module amplitude_ramp_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int GAIN_WIDTH = 16,
  parameter int N_CH       = 2
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic signed [GAIN_WIDTH-1:0]  target_gain,
  input  logic [GAIN_WIDTH-2:0]         ramp_step,
  input  logic                          gain_load,
  input  logic [N_CH*DATA_WIDTH-1:0]    data_i_tdata,
  input  logic                          data_i_tvalid,
  output logic                          data_i_tready,
  output logic [N_CH*DATA_WIDTH-1:0]    data_o_tdata,
  output logic                          data_o_tvalid,
  input  logic                          data_o_tready,
  output logic [N_CH-1:0]               data_o_sat,
  output logic signed [GAIN_WIDTH-1:0]  gain_cur,
  output logic                          ramp_busy
);

  localparam int PW = DATA_WIDTH + GAIN_WIDTH;
  localparam int RW = DATA_WIDTH + 2;

  localparam logic signed [PW:0] ROUND_C =
    {{(PW + 2 - GAIN_WIDTH){1'b0}}, 1'b1, {(GAIN_WIDTH-2){1'b0}}};
  localparam logic signed [RW-1:0] SMAX =
    {{(RW - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] SMIN =
    {{(RW - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  // Round half-up: add half an LSB of the Q1.(GAIN_WIDTH-1) scale, then drop the fraction.
  function automatic logic signed [RW-1:0] round_half_up(input logic signed [PW-1:0] p);
    logic signed [PW:0] t;
    t = $signed({p[PW-1], p}) + ROUND_C;
    return $signed(t[PW:GAIN_WIDTH-1]);
  endfunction

  // Returns {sat, value}.
  function automatic logic [DATA_WIDTH:0] saturate(input logic signed [RW-1:0] r);
    if (r > SMAX) return {1'b1, SMAX[DATA_WIDTH-1:0]};
    if (r < SMIN) return {1'b1, SMIN[DATA_WIDTH-1:0]};
    return {1'b0, r[DATA_WIDTH-1:0]};
  endfunction

  state_t                       state, state_nx;
  logic signed [GAIN_WIDTH-1:0] target, target_nx, gain_nx;
  logic [GAIN_WIDTH-2:0]        step, step_nx;
  logic signed [GAIN_WIDTH:0]   g_ext, t_ext, step_ext, up_sum, dn_sum;
  logic                         advance, accept;

  logic signed [PW-1:0]         prod_nx [N_CH];
  logic signed [PW-1:0]         prod_p1 [N_CH];
  logic                         vld_p1;
  logic [DATA_WIDTH:0]          rs_nx   [N_CH];
  logic [N_CH*DATA_WIDTH-1:0]   data_nx, data_p2;
  logic [N_CH-1:0]              sat_nx, sat_p2;
  logic                         vld_p2;

  assign advance       = !vld_p2 || data_o_tready;
  assign accept        = data_i_tvalid && advance;
  assign data_i_tready = advance;
  assign data_o_tdata  = data_p2;
  assign data_o_sat    = sat_p2;
  assign data_o_tvalid = vld_p2;

  always_comb begin
    g_ext     = {gain_cur[GAIN_WIDTH-1], gain_cur};
    t_ext     = {target[GAIN_WIDTH-1], target};
    step_ext  = {2'b00, step};
    up_sum    = g_ext + step_ext;
    dn_sum    = g_ext - step_ext;
    state_nx  = state;
    gain_nx   = gain_cur;
    target_nx = target;
    step_nx   = step;
    if (gain_load) begin
      target_nx = target_gain;
      step_nx   = ramp_step;
      if (ramp_step == '0) begin
        gain_nx  = target_gain;
        state_nx = IDLE;
      end else if (gain_cur < target_gain) begin
        state_nx = UP;
      end else if (gain_cur > target_gain) begin
        state_nx = DOWN;
      end else begin
        state_nx = IDLE;
      end
    end else if (accept) begin
      // One extra bit on the sums so a step near full scale clamps instead of wrapping.
      if (state == UP) begin
        if (up_sum >= t_ext) begin
          gain_nx  = target;
          state_nx = IDLE;
        end else begin
          gain_nx = up_sum[GAIN_WIDTH-1:0];
        end
      end else if (state == DOWN) begin
        if (dn_sum <= t_ext) begin
          gain_nx  = target;
          state_nx = IDLE;
        end else begin
          gain_nx = dn_sum[GAIN_WIDTH-1:0];
        end
      end
    end
  end

  always_comb begin
    data_nx = '0;
    sat_nx  = '0;
    for (int k = 0; k < N_CH; k++) begin
      prod_nx[k] = PW'($signed(data_i_tdata[k*DATA_WIDTH +: DATA_WIDTH])) * PW'(gain_cur);
      rs_nx[k]   = saturate(round_half_up(prod_p1[k]));
      data_nx[k*DATA_WIDTH +: DATA_WIDTH] = rs_nx[k][DATA_WIDTH-1:0];
      sat_nx[k]  = rs_nx[k][DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      gain_cur  <= '0;
      target    <= '0;
      step      <= '0;
      ramp_busy <= 1'b0;
      vld_p1    <= 1'b0;
      vld_p2    <= 1'b0;
      data_p2   <= '0;
      sat_p2    <= '0;
    end else begin
      state     <= state_nx;
      gain_cur  <= gain_nx;
      target    <= target_nx;
      step      <= step_nx;
      ramp_busy <= (state_nx != IDLE);
      // S1 -> S2 boundary: everything moves together only on advance.
      if (advance) begin
        vld_p1 <= data_i_tvalid;
        vld_p2 <= vld_p1;
        if (vld_p1) begin
          data_p2 <= data_nx;
          sat_p2  <= sat_nx;
        end
      end
    end
  end

  // Input -> S1 boundary: full-precision products, captured only for real beats.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < N_CH; k++) prod_p1[k] <= prod_nx[k];
    end
  end

endmodule

// File: tb/tb_amplitude_ramp_ctrl.sv
// Directed bench for amplitude_ramp_ctrl: arithmetic vector table, ramp sequences,
// randomized backpressure against a behavioural model, retarget and mid-stream reset.
module tb_amplitude_ramp_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] target_gain;
  logic [14:0] ramp_step;
  logic        gain_load;
  logic [31:0] data_i_tdata;
  logic        data_i_tvalid;
  logic        data_i_tready;
  logic [31:0] data_o_tdata;
  logic        data_o_tvalid;
  logic        data_o_tready;
  logic [1:0]  data_o_sat;
  logic [15:0] gain_cur;
  logic        ramp_busy;

  int n_checks = 0;
  int n_fail   = 0;

  amplitude_ramp_ctrl #(.DATA_WIDTH(16), .GAIN_WIDTH(16), .N_CH(2)) dut (
    .clk(clk), .resetn(resetn),
    .target_gain(target_gain), .ramp_step(ramp_step), .gain_load(gain_load),
    .data_i_tdata(data_i_tdata), .data_i_tvalid(data_i_tvalid), .data_i_tready(data_i_tready),
    .data_o_tdata(data_o_tdata), .data_o_tvalid(data_o_tvalid), .data_o_tready(data_o_tready),
    .data_o_sat(data_o_sat), .gain_cur(gain_cur), .ramp_busy(ramp_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] gain;
    logic [15:0] x0, x1;
    logic [15:0] e0, e1;
    logic [1:0]  sat;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] g, input logic [14:0] s);
    target_gain = g;
    ramp_step   = s;
    gain_load   = 1'b1;
    tick();
    gain_load   = 1'b0;
  endtask

  function automatic vec_t mk(input int g, input int x0, input int x1,
                              input int e0, input int e1, input logic [1:0] sat);
    vec_t v;
    v.gain = 16'(g); v.x0 = 16'(x0); v.x1 = 16'(x1);
    v.e0 = 16'(e0); v.e1 = 16'(e1); v.sat = sat;
    return v;
  endfunction

  // Reference: {sat, value} for one channel.
  function automatic logic [16:0] mdl(input logic [15:0] x, input logic [15:0] g);
    int p, r;
    p = int'($signed(x)) * int'($signed(g));
    r = (p + 16384) >>> 15;
    if (r > 32767)  return {1'b1, 16'h7FFF};
    if (r < -32768) return {1'b1, 16'h8000};
    return {1'b0, r[15:0]};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] seq_a [4];
    logic [15:0] seq_b [6];
    logic [15:0] seq_c [4];
    logic [33:0] q [$];
    logic [33:0] exp_o, hold_val;
    logic [16:0] m0, m1;
    logic [31:0] cur_data;
    logic [15:0] mgain, mtarget;
    int          mstep, gi, ti, sent, got, cyc;
    logic        hold;

    vecs[0] = mk('h7FFF,   1000,  -1000,   1000,  -1000, 2'b00);
    vecs[1] = mk('h7FFF,  32767,      0,  32766,      0, 2'b00);
    vecs[2] = mk('h8000, -32768,  16384,  32767, -16384, 2'b01);
    vecs[3] = mk('h4000,      3,     -3,      2,     -1, 2'b00);
    vecs[4] = mk('h4000,      1,     -1,      1,      0, 2'b00);
    vecs[5] = mk('h8000, -32768, -32768,  32767,  32767, 2'b11);
    vecs[6] = mk('h7FFF, -32768,  12345, -32767,  12345, 2'b00);
    vecs[7] = mk('h0000,   1234,     -5,      0,      0, 2'b00);
    seq_a = '{16'h0400, 16'h0800, 16'h0C00, 16'h1000};
    seq_b = '{16'h0300, 16'h0600, 16'h0900, 16'h0C00, 16'h0F00, 16'h1000};
    seq_c = '{16'h0600, 16'h0400, 16'h0200, 16'h0000};

    resetn = 1'b0; target_gain = '0; ramp_step = '0; gain_load = 1'b0;
    data_i_tdata = '0; data_i_tvalid = 1'b0; data_o_tready = 1'b1;
    repeat (3) tick();
    chk("rst_tvalid", data_o_tvalid, 0);
    chk("rst_tdata", data_o_tdata, 0);
    chk("rst_sat", data_o_sat, 0);
    chk("rst_gain", gain_cur, 0);
    chk("rst_busy", ramp_busy, 0);
    chk("rst_tready", data_i_tready, 1);
    resetn = 1'b1;
    tick();

    // Arithmetic table: immediate gain load, one beat, two-cycle latency.
    for (int i = 0; i < 8; i++) begin
      load(vecs[i].gain, 15'd0);
      chk($sformatf("v%0d_gain", i), gain_cur, vecs[i].gain);
      chk($sformatf("v%0d_busy", i), ramp_busy, 0);
      data_i_tdata  = {vecs[i].x1, vecs[i].x0};
      data_i_tvalid = 1'b1;
      tick();
      data_i_tvalid = 1'b0;
      chk($sformatf("v%0d_lat1", i), data_o_tvalid, 0);
      tick();
      chk($sformatf("v%0d_vld", i), data_o_tvalid, 1);
      chk($sformatf("v%0d_ch0", i), data_o_tdata[15:0], vecs[i].e0);
      chk($sformatf("v%0d_ch1", i), data_o_tdata[31:16], vecs[i].e1);
      chk($sformatf("v%0d_sat", i), data_o_sat, vecs[i].sat);
      tick();
      chk($sformatf("v%0d_drain", i), data_o_tvalid, 0);
    end

    // Ramp up by an exact divisor of the distance.
    load(16'h0000, 15'd0);
    load(16'h1000, 15'h0400);
    chk("rampA_hold_on_load", gain_cur, 16'h0000);
    chk("rampA_busy", ramp_busy, 1);
    data_i_tdata = 32'h0100_0100;
    data_i_tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rampA_g%0d", i), gain_cur, seq_a[i]);
    end
    data_i_tvalid = 1'b0;
    chk("rampA_done", ramp_busy, 0);
    tick(); tick();

    // Ramp up with a step that would overshoot on the last beat.
    load(16'h0000, 15'd0);
    load(16'h1000, 15'h0300);
    data_i_tvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("rampB_g%0d", i), gain_cur, seq_b[i]);
    end
    data_i_tvalid = 1'b0;
    chk("rampB_done", ramp_busy, 0);
    tick();
    chk("rampB_freeze", gain_cur, 16'h1000);
    tick();

    // Randomized backpressure with a ramp in progress.
    load(16'h0000, 15'd0);
    load(16'h7000, 15'h0100);
    mgain = 16'h0000; mtarget = 16'h7000; mstep = 'h100;
    sent = 0; got = 0; cyc = 0; hold = 1'b0; hold_val = '0;
    cur_data = $urandom;
    while ((sent < 100 || got < 100) && cyc < 3000) begin
      data_i_tvalid = (sent < 100) && ($urandom_range(0, 9) < 7);
      data_i_tdata  = cur_data;
      data_o_tready = 1'($urandom_range(0, 1));
      #2;
      if (hold) begin
        chk("bp_hold_vld", data_o_tvalid, 1);
        chk("bp_hold_data", {data_o_sat, data_o_tdata}, hold_val);
      end
      hold     = data_o_tvalid && !data_o_tready;
      hold_val = {data_o_sat, data_o_tdata};
      chk("bp_gain", gain_cur, mgain);
      if (data_o_tvalid && data_o_tready) begin
        if (q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL bp_extra: got beat 0x%0h expected none", data_o_tdata);
        end else begin
          exp_o = q.pop_front();
          chk("bp_out", {data_o_sat, data_o_tdata}, exp_o);
        end
        got++;
      end
      if (data_i_tvalid && data_i_tready) begin
        m0 = mdl(cur_data[15:0], mgain);
        m1 = mdl(cur_data[31:16], mgain);
        q.push_back({m1[16], m0[16], m1[15:0], m0[15:0]});
        gi = int'($signed(mgain)); ti = int'($signed(mtarget));
        if (gi < ti) begin
          gi = gi + mstep; if (gi >= ti) gi = ti;
        end else if (gi > ti) begin
          gi = gi - mstep; if (gi <= ti) gi = ti;
        end
        mgain = 16'(gi);
        sent++;
        cur_data = $urandom;
      end
      @(posedge clk); #1;
      cyc++;
    end
    data_i_tvalid = 1'b0;
    data_o_tready = 1'b1;
    if (cyc >= 3000) begin
      n_checks++; n_fail++;
      $display("FAIL bp_timeout: got %0d beats expected 100", got);
    end
    chk("bp_count", got, 100);
    chk("bp_queue_empty", q.size(), 0);
    tick(); tick();

    // Retarget downward mid-ramp; beat in the load cycle must not step.
    load(16'h0000, 15'd0);
    load(16'h1000, 15'h0400);
    data_i_tvalid = 1'b1;
    tick(); tick();
    chk("rt_up_0800", gain_cur, 16'h0800);
    target_gain = 16'h0000; ramp_step = 15'h0200; gain_load = 1'b1;
    tick();
    gain_load = 1'b0;
    chk("rt_load_prio", gain_cur, 16'h0800);
    chk("rt_busy", ramp_busy, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("rt_g%0d", i), gain_cur, seq_c[i]);
    end
    chk("rt_done", ramp_busy, 0);

    // Reset with beats in flight.
    load(16'h7FFF, 15'd0);
    data_i_tdata = 32'h1234_5678;
    tick(); tick();
    chk("mid_vld_before", data_o_tvalid, 1);
    resetn = 1'b0;
    tick();
    chk("mid_rst_vld", data_o_tvalid, 0);
    chk("mid_rst_data", data_o_tdata, 0);
    chk("mid_rst_sat", data_o_sat, 0);
    chk("mid_rst_gain", gain_cur, 0);
    chk("mid_rst_busy", ramp_busy, 0);
    resetn = 1'b1;
    data_i_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("post_rst_vld%0d", i), data_o_tvalid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
